// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and a width helper used by rx and tx.
// Latency: n/a (types and constant functions only).
// Backpressure: n/a.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_state_t;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int clog2w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/uart_rx_sampler.sv
// Two-flop rx synchroniser plus 3-sample majority voter around mid-bit.
// Latency: rs lags rx by 2 clk; voted_bit is valid combinationally at tick OVERSAMPLE/2+1.
// Backpressure: none; samples are captured only on sample_tick.
module uart_rx_sampler #(
    parameter int OVERSAMPLE = 16,
    parameter int TW         = 4
) (
    input  logic          clk,
    input  logic          reset_n,
    input  logic          sample_tick,
    input  logic          rx,
    input  logic [TW-1:0] tick_cnt,
    output logic          rs,
    output logic          voted_bit
);
    localparam logic [TW-1:0] SAMPLE0_TICK = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] SAMPLE1_TICK = TW'(OVERSAMPLE / 2);

    logic r_sync1;
    logic r_sync2;
    logic r_s0;
    logic r_s1;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_s0    <= 1'b0;
            r_s1    <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            if (sample_tick && tick_cnt == SAMPLE0_TICK) r_s0 <= r_sync2;
            if (sample_tick && tick_cnt == SAMPLE1_TICK) r_s1 <= r_sync2;
        end
    end

    // Third sample is the live rs at the decision tick.
    assign rs        = r_sync2;
    assign voted_bit = (r_s0 & r_s1) | (r_s0 & r_sync2) | (r_s1 & r_sync2);

endmodule

// File: rtl/uart_rx_os.sv
// Oversampling UART receiver, 5-9 data bits, 1-2 stop bits; parity built in with UART_RX_PARITY_EN.
// Latency: dout_valid rises on the clk edge that samples the final stop-bit vote tick.
// Backpressure: one-word holding register; a word completing while it is full and not accepted is dropped with an overrun pulse.
module uart_rx_os
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16,
    parameter int STOP_BITS  = 1,
    parameter int PARITY_ODD = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 sample_tick,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] dout,
    output logic                 dout_valid,
    input  logic                 dout_ready,
    output logic                 frame_err,
    output logic                 parity_err,
    output logic                 overrun,
    output logic                 busy
);
    localparam int TW = clog2w(OVERSAMPLE);
    localparam int BW = clog2w(DATA_BITS + 1);
    localparam logic [TW-1:0] VOTE_TICK = TW'(OVERSAMPLE / 2 + 1);
    localparam logic [TW-1:0] LAST_TICK = TW'(OVERSAMPLE - 1);

    if (DATA_BITS < 5 || DATA_BITS > 9 || OVERSAMPLE < 8 || (OVERSAMPLE % 2) != 0 ||
        STOP_BITS < 1 || STOP_BITS > 2 || PARITY_ODD < 0 || PARITY_ODD > 1) begin : g_bad_params
        $error("uart_rx_os: illegal parameter set");
    end

    uart_state_t          r_state;
    logic [TW-1:0]        r_tick;
    logic [BW-1:0]        r_bit;
    logic [DATA_BITS-1:0] r_shift;
    logic                 r_ferr;
    logic                 r_armed;
`ifdef UART_RX_PARITY_EN
    logic                 r_perr;
`endif

    logic w_rs;
    logic w_voted;
    logic w_vote_pt;
    logic w_last_pt;
    logic w_commit;
    logic w_frame_err;

    uart_rx_sampler #(.OVERSAMPLE(OVERSAMPLE), .TW(TW)) u_sampler (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .rx          (rx),
        .tick_cnt    (r_tick),
        .rs          (w_rs),
        .voted_bit   (w_voted)
    );

    assign w_vote_pt   = (r_tick == VOTE_TICK);
    assign w_last_pt   = (r_tick == LAST_TICK);
    assign w_commit    = sample_tick && r_state == ST_STOP && w_vote_pt && r_bit == BW'(STOP_BITS - 1);
    assign w_frame_err = r_ferr | ~w_voted;
    assign busy        = (r_state != ST_IDLE);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= ST_IDLE;
            r_tick  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_ferr  <= 1'b0;
            r_armed <= 1'b1;
`ifdef UART_RX_PARITY_EN
            r_perr  <= 1'b0;
`endif
        end else if (sample_tick) begin
            case (r_state)
                ST_IDLE: begin
                    r_tick <= '0;
                    r_bit  <= '0;
                    // After a break the line must return high before a new start is accepted.
                    if (!r_armed) begin
                        r_armed <= w_rs;
                    end else if (!w_rs) begin
                        r_state <= ST_START;
                        r_ferr  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                        r_perr  <= 1'b0;
`endif
                    end
                end
                ST_START: begin
                    if (w_vote_pt && w_voted) begin
                        r_state <= ST_IDLE;
                        r_tick  <= '0;
                    end else if (w_last_pt) begin
                        r_state <= ST_DATA;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (w_vote_pt) begin
                        r_shift <= {w_voted, r_shift[DATA_BITS-1:1]};
                        r_bit   <= r_bit + 1'b1;
                    end
                    if (w_last_pt) begin
                        r_tick <= '0;
                        if (r_bit == BW'(DATA_BITS)) begin
                            r_bit <= '0;
`ifdef UART_RX_PARITY_EN
                            r_state <= ST_PARITY;
`else
                            r_state <= ST_STOP;
`endif
                        end
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`ifdef UART_RX_PARITY_EN
                ST_PARITY: begin
                    if (w_vote_pt) r_perr <= w_voted ^ (^r_shift) ^ PARITY_ODD[0];
                    if (w_last_pt) begin
                        r_state <= ST_STOP;
                        r_tick  <= '0;
                    end else begin
                        r_tick <= r_tick + 1'b1;
                    end
                end
`endif
                ST_STOP: begin
                    r_tick <= w_last_pt ? '0 : r_tick + 1'b1;
                    if (w_vote_pt) begin
                        if (!w_voted) r_ferr <= 1'b1;
                        if (r_bit == BW'(STOP_BITS - 1)) begin
                            // Leave mid-stop-bit so a back-to-back start edge is not missed.
                            r_state <= ST_IDLE;
                            r_tick  <= '0;
                            r_bit   <= '0;
                            if (r_shift == '0 && w_frame_err) r_armed <= 1'b0;
                        end else begin
                            r_bit <= r_bit + 1'b1;
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            dout       <= '0;
            dout_valid <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err <= 1'b0;
`endif
        end else begin
            overrun <= 1'b0;
            if (w_commit) begin
                if (!dout_valid || dout_ready) begin
                    dout       <= r_shift;
                    dout_valid <= 1'b1;
                    frame_err  <= w_frame_err;
`ifdef UART_RX_PARITY_EN
                    parity_err <= r_perr;
`endif
                end else begin
                    overrun <= 1'b1;
                end
            end else if (dout_valid && dout_ready) begin
                dout_valid <= 1'b0;
                frame_err  <= 1'b0;
`ifdef UART_RX_PARITY_EN
                parity_err <= 1'b0;
`endif
            end
        end
    end

`ifndef UART_RX_PARITY_EN
    assign parity_err = 1'b0;
`endif

endmodule

// File: tb/tb_uart_rx_os.sv
// Bench for uart_rx_os (8 data bits, x16 oversample, 1 stop bit); parity cases follow UART_RX_PARITY_EN.
module tb_uart_rx_os;
    localparam int OS = 16;
`ifdef UART_RX_PARITY_EN
    localparam bit PAR_EN = 1'b1;
`else
    localparam bit PAR_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       sample_tick = 1'b0;
    logic       rx = 1'b1;
    logic       dout_ready = 1'b0;
    logic [7:0] dout;
    logic       dout_valid, frame_err, parity_err, overrun, busy;

    int n_tests = 0;
    int n_fail  = 0;
    int ovr_cnt = 0;
    int vld_run = 0;
    int max_run = 0;
    int ovr0;
    logic [9:0] got_q[$];
    logic [9:0] exp_q[$];

    uart_rx_os dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .sample_tick (sample_tick),
        .rx          (rx),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .frame_err   (frame_err),
        .parity_err  (parity_err),
        .overrun     (overrun),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(posedge clk);
            #1 sample_tick = 1'b1;
            @(posedge clk);
            #1 sample_tick = 1'b0;
        end
    end

    // Record accepted words and overrun pulses, sampled away from the active edge.
    always @(negedge clk) begin
        if (dout_valid && dout_ready) got_q.push_back({dout, frame_err, parity_err});
        if (overrun) ovr_cnt++;
        if (dout_valid) vld_run++;
        else vld_run = 0;
        if (vld_run > max_run) max_run = vld_run;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_tick();
        @(posedge clk);
        while (sample_tick !== 1'b1) @(posedge clk);
        #2;
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) wait_tick();
    endtask

    // One bit period; gl (1..OS) inverts the line for exactly that tick slot.
    task automatic send_bit(input logic b, input int gl);
        for (int i = 1; i <= OS; i++) begin
            rx = (i == gl) ? ~b : b;
            wait_tick();
        end
    endtask

    task automatic send_frame(input logic [7:0] d, input logic stop_v, input int glitch_bit,
                              input logic par_flip, input bit acc_at_commit,
                              input bit chk_busy, input bit expect_word);
        send_bit(1'b0, 0);
        for (int j = 0; j < 8; j++) send_bit(d[j], (j == glitch_bit) ? 10 : 0);
        if (PAR_EN) send_bit((^d) ^ par_flip, 0);
        rx = stop_v;
        for (int i = 1; i <= OS; i++) begin
            if (i == 11 && acc_at_commit) begin
                repeat (3) @(posedge clk);
                #2 dout_ready = 1'b1;
                @(posedge clk);
                #2 dout_ready = 1'b0;
            end else begin
                wait_tick();
            end
            if (chk_busy && i == 10) check("busy_before_stop_vote", busy, 1);
            if (chk_busy && i == 11) check("busy_after_stop_vote", busy, 0);
        end
        if (expect_word) exp_q.push_back({d, ~stop_v, par_flip & PAR_EN});
    endtask

    task automatic compare_q(input string tag);
        check({tag, "_word_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++)
            if (i < got_q.size()) check({tag, "_word"}, {22'd0, got_q[i]}, {22'd0, exp_q[i]});
        got_q.delete();
        exp_q.delete();
    endtask

    initial begin
        logic [7:0] d;
        logic       sv;
        logic       pf;
        int         g;

        #23;
        check("reset_dout", dout, 0);
        check("reset_valid", dout_valid, 0);
        check("reset_busy", busy, 0);
        check("reset_errs", {frame_err, parity_err, overrun}, 0);
        reset_n = 1'b1;
        idle(20);

        // Single clean frame, consumer always ready.
        dout_ready = 1'b1;
        max_run = 0;
        send_frame(8'hA5, 1'b1, -1, 1'b0, 1'b0, 1'b1, 1'b1);
        idle(20);
        check("valid_one_clk", max_run, 1);
        compare_q("clean_a5");

        // False start: 4 ticks low.
        rx = 1'b0;
        repeat (4) wait_tick();
        check("false_start_busy", busy, 1);
        idle(40);
        check("false_start_idle", busy, 0);
        compare_q("false_start");

        // Bad stop bit, then line held low: one framed word, one break word, then silence.
        send_frame(8'h3C, 1'b0, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        rx = 1'b0;
        repeat (10 * OS) wait_tick();
        exp_q.push_back({8'h00, 1'b1, 1'b0});
        check("break_waits_idle", busy, 0);
        idle(40);
        compare_q("break");

        // Overrun: holding register full, second word dropped.
        dout_ready = 1'b0;
        ovr0 = ovr_cnt;
        send_frame(8'h11, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(8);
        check("overrun_dout", dout, 8'h11);
        check("overrun_valid", dout_valid, 1);
        check("overrun_pulses", ovr_cnt - ovr0, 1);
        dout_ready = 1'b1;
        @(posedge clk);
        #2 dout_ready = 1'b0;
        idle(8);
        // Accept on the commit clk: new word replaces the old, no overrun.
        ovr0 = ovr_cnt;
        send_frame(8'h11, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        send_frame(8'h22, 1'b1, -1, 1'b0, 1'b1, 1'b0, 1'b1);
        idle(4);
        check("same_clk_dout", dout, 8'h22);
        check("same_clk_valid", dout_valid, 1);
        check("same_clk_no_overrun", ovr_cnt - ovr0, 0);
        dout_ready = 1'b1;
        idle(8);
        compare_q("handshake");

        // Parity sense and centre-sample glitch rejection.
        send_frame(8'h07, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(8);
        send_frame(8'h07, 1'b1, -1, 1'b1, 1'b0, 1'b0, 1'b1);
        idle(8);
        send_frame(8'h07, 1'b1, 1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(8);
        send_frame(8'h07, 1'b1, 5, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(8);
        compare_q("parity_glitch");

        // Asynchronous reset in the middle of data bit 3.
        dout_ready = 1'b0;
        send_frame(8'h66, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b0);
        idle(4);
        check("pre_reset_valid", dout_valid, 1);
        d = 8'h5A;
        send_bit(1'b0, 0);
        for (int j = 0; j < 3; j++) send_bit(d[j], 0);
        rx = d[3];
        repeat (5) wait_tick();
        #1 reset_n = 1'b0;
        #1;
        check("async_reset_valid", dout_valid, 0);
        check("async_reset_dout", dout, 0);
        check("async_reset_busy", busy, 0);
        check("async_reset_ferr", frame_err, 0);
        #20 reset_n = 1'b1;
        idle(20);
        dout_ready = 1'b1;
        send_frame(8'h5A, 1'b1, -1, 1'b0, 1'b0, 1'b0, 1'b1);
        idle(8);
        compare_q("after_reset");

        // Randomised frames: data, stop-bit validity, glitch position, parity flip.
        for (int k = 0; k < 10; k++) begin
            d  = 8'($urandom);
            sv = ($urandom_range(0, 3) != 0);
            pf = 1'($urandom_range(0, 1));
            g  = int'($urandom_range(0, 8));
            if (g == 8) g = -1;
            send_frame(d, sv, g, pf, 1'b0, 1'b0, 1'b1);
            idle(2 * OS);
        end
        compare_q("random");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
Oversampling UART receiver, the parametrised successor to the baud-tick receiver.
- Synchronises the async rx line and detects the start edge at oversample resolution.
- Majority-votes each bit at mid-bit; supports 5-9 data bits and 1 or 2 stop bits.
- Delivers each word through a valid/ready holding register with frame, parity and overrun status.
- Sits between the pin and the host-side FIFO/register file.

Parameters:
DATA_BITS, 8, data bits per frame; legal range 5..9; sent LSB first.
OVERSAMPLE, 16, sample_tick periods per bit; even, >= 8.
STOP_BITS, 1, stop bits checked per frame; 1 or 2.
PARITY_ODD, 0, parity sense when parity is compiled in: 0 = even, 1 = odd.

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
sample_tick  input  1  one-clk strobe at OVERSAMPLE x baud rate
rx  input  1  asynchronous serial line; idle high
dout  output  DATA_BITS  received word; stable while dout_valid = 1
dout_valid  output  1  word available; held until accepted
dout_ready  input  1  consumer accepts the word when dout_valid & dout_ready
frame_err  output  1  status of the held word: a stop bit sampled 0
parity_err  output  1  status of the held word: parity mismatch
overrun  output  1  one-clk pulse: a completed word was dropped
busy  output  1  high whenever state != IDLE

Behaviour:
- Reset:
  - Clock is clk; reset_n is asynchronous and active-low.
  - dout = 0; dout_valid, frame_err, parity_err, overrun and busy = 0.
  - Synchroniser flops reset to 1. State = IDLE, all counters = 0.
- Synchronisation: rx passes through a 2-flop synchroniser; all decisions use the synchronised value rs.
- State and counters advance only on sample_tick. The output handshake is evaluated on every clk.
- tick_cnt width is clog2(OVERSAMPLE); bit_cnt width is clog2(DATA_BITS+1).
- Vote: majority of rs sampled at tick_cnt = OVERSAMPLE/2-1, OVERSAMPLE/2 and OVERSAMPLE/2+1. The bit decision is taken at OVERSAMPLE/2+1.
- States:
  - IDLE: when rs == 0, go to START with tick_cnt = 0.
  - START:
    - At the vote point, a voted 1 is a false start: go to IDLE with no output.
    - A voted 0 continues; at tick_cnt = OVERSAMPLE-1, wrap tick_cnt and go to DATA.
  - DATA:
    - Shift in the voted bit each bit period, LSB first.
    - After DATA_BITS bits, go to PARITY if compiled in, else STOP.
  - PARITY: one bit period; compare the voted bit with the XOR of the data bits (inverted when PARITY_ODD = 1).
  - STOP:
    - Vote each of STOP_BITS bits; frame_err_next = 1 if any stop bit votes 0.
    - After the last stop-bit vote, commit the word and go to IDLE immediately (mid-stop-bit) so back-to-back frames are caught.
- Commit latency: dout_valid rises on the clk after the sample_tick carrying the final stop-bit vote.
- Commit when the holding register is empty: load dout, frame_err and parity_err; set dout_valid.
- Commit when dout_valid = 1 and no accept that cycle:
  - The new word is dropped and overrun pulses for 1 clk.
  - dout and its status are unchanged.
- Commit in the same clk as an accept: the new word is loaded, dout_valid stays 1, no overrun.
- Accept without commit: dout_valid clears next clk. frame_err and parity_err clear with it.
- Break condition (rx low for a whole frame): delivered as dout = 0 with frame_err = 1. The receiver then waits in IDLE for rs high before re-arming, so there is no repeated start.
- reset_n asserted mid-frame: immediate return to IDLE; any partial word is discarded.

Optional Feature:
UART_RX_PARITY_EN
- Defined: PARITY state is present and parity_err reflects the check.
- Undefined: no PARITY state, frame length = 1 + DATA_BITS + STOP_BITS bits, and parity_err is tied 0.
- The port list is identical in both builds.

Decomposition:
- Package uart_pkg: state encoding constants (IDLE, START, DATA, PARITY, STOP) and a clog2 width helper, shared with uart_tx.
- Sub-module uart_rx_sampler: 2-flop synchroniser plus the 3-sample majority voter. Inputs: rx, sample_tick, tick_cnt. Outputs: rs, voted_bit.

Test Plan:
1. OVERSAMPLE = 16, 8N1, dout_ready = 1, frame 0xA5 -> dout = 0xA5, dout_valid high 1 clk, frame_err = parity_err = 0, busy falls mid-stop.
2. rx low for 4 sample_ticks, then high -> false start, back to IDLE, no dout_valid.
3. Frame 0x3C with stop bit driven 0; then rx held low 10 bit periods -> first dout = 0x3C with frame_err = 1; then one dout = 0x00 with frame_err = 1; no further words until rx returns high.
4. dout_ready = 0, back-to-back frames 0x11, 0x22 -> dout stays 0x11, overrun pulses 1 clk at the second commit. Repeat with dout_ready asserted on the commit clk -> dout = 0x22, no overrun.
5. UART_RX_PARITY_EN, PARITY_ODD = 0, data 0x07:
   - Parity bit 1 -> parity_err = 0.
   - Parity bit 0 -> parity_err = 1.
   - Single-tick glitch inverting one centre sample -> bit corrected by the vote.
6. reset_n pulsed low during DATA bit 3 -> all outputs 0 asynchronously; the following frame 0x5A is received cleanly.
